// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with power-of-two depth.
// Tracks occupancy and raises almost-full/almost-empty at programmable thresholds.
// Overflow and underflow are sticky error flags.
// Read port is either a registered read (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo #(
  parameter int D_BITS    = 8,
  parameter int ADDR_BITS = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 4,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [D_BITS-1:0]    din,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [D_BITS-1:0]    dout,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS + 1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_C    = (ADDR_BITS + 1)'(AE_LEVEL);

  logic [D_BITS-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS-1:0] rd_ptr_nxt;
  logic [ADDR_BITS:0]   count_nxt;
  logic                 wr_ok;
  logic                 rd_ok;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Accept decisions from pre-edge state; a full FIFO can still take a write when a read drains it.
  always_comb begin
    rd_ok      = rd_en & ~empty;
    wr_ok      = wr_en & (~full | rd_ok);
    rd_ptr_nxt = rd_ok ? rd_ptr + ADDR_BITS'(1) : rd_ptr;
    count_nxt  = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + (ADDR_BITS + 1)'(1);
      2'b01:   count_nxt = count - (ADDR_BITS + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      overflow  <= (wr_en & full & ~rd_ok) | (overflow & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Preload the word that will be oldest after this edge.
    // A write into an empty slot is forwarded from din because mem is not yet updated.
    always_ff @(posedge clk) begin
      if (reset) begin
        dout <= '0;
      end else if (count_nxt != '0) begin
        if (wr_ok && (wr_ptr == rd_ptr_nxt)) dout <= din;
        else                                 dout <= mem[rd_ptr_nxt];
      end
    end
  end else begin : g_std
    // Registered read: the word appears the cycle after an accepted read and then holds.
    always_ff @(posedge clk) begin
      if (reset)      dout <= '0;
      else if (rd_ok) dout <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: checks a standard-read and a FWFT instance driven by the same stimulus
// against a queue-based reference model of the FIFO.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;

  int tests = 0;
  int fails = 0;

  // reference model
  logic [7:0] q[$];
  logic [7:0] m_std = 8'h00;
  logic [7:0] m_fwft = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(.D_BITS(8), .ADDR_BITS(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0));

  sync_fifo #(.D_BITS(8), .ADDR_BITS(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1));

  wire [10:0] st0 = {count0, full0, empty0, af0, ae0, ovf0, unf0};
  wire [10:0] st1 = {count1, full1, empty1, af1, ae1, ovf1, unf1};

  // expected {count, full, empty, almost_full, almost_empty, overflow, underflow}
  function automatic logic [10:0] exp_status();
    int n;
    n = q.size();
    return {5'(n), n == 16, n == 0, n >= 12, n <= 4, m_ovf, m_unf};
  endfunction

  // Apply one cycle of inputs, advance the model over the edge, settle 1 ns after it.
  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit clr, input bit rst);
    int  n;
    bit  rd_ok, wr_ok;
    wr_en = w; rd_en = r; din = d; clr_err = clr; reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_std = 8'h00; m_fwft = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      n     = q.size();
      rd_ok = r && (n > 0);
      wr_ok = w && ((n < 16) || rd_ok);
      m_ovf = (w && n == 16 && !rd_ok) || (m_ovf && !clr);
      m_unf = (r && n == 0) || (m_unf && !clr);
      if (rd_ok) m_std = q.pop_front();
      if (wr_ok) q.push_back(d);
      if (q.size() > 0) m_fwft = q[0];
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 0, 8'h00, 0, 1);
    tests++;
    if (st0 !== 11'b00000_0_1_0_1_0_0 || st1 !== 11'b00000_0_1_0_1_0_0) begin
      fails++;
      $display("FAIL reset_status std=%b fwft=%b required=%b", st0, st1, 11'b00000_0_1_0_1_0_0);
    end
    tests++;
    if (dout0 !== 8'h00 || dout1 !== 8'h00) begin
      fails++;
      $display("FAIL reset_dout std=%h fwft=%h required=00", dout0, dout1);
    end
  endtask

  task automatic test_fill();
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i), 0, 0);
      tests++;
      if (st0 !== exp_status() || st1 !== exp_status()) begin
        fails++;
        $display("FAIL fill_status[%0d] std=%b fwft=%b required=%b", i, st0, st1, exp_status());
      end
      tests++;
      if (af0 !== (i + 1 >= 12) || count0 !== 5'(i + 1)) begin
        fails++;
        $display("FAIL fill_af[%0d] af=%b count=%0d required af=%b count=%0d", i, af0, count0, i + 1 >= 12, i + 1);
      end
    end
    step(1, 0, 8'hAA, 0, 0);
    tests++;
    if (ovf0 !== 1'b1 || count0 !== 5'd16 || full0 !== 1'b1 || st1 !== exp_status()) begin
      fails++;
      $display("FAIL overflow ovf=%b count=%0d full=%b required ovf=1 count=16 full=1", ovf0, count0, full0);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'h00, 0, 0);
      tests++;
      if (dout0 !== 8'(i) || dout0 !== m_std) begin
        fails++;
        $display("FAIL drain_dout[%0d] got=%h required=%h", i, dout0, 8'(i));
      end
      tests++;
      if (st0 !== exp_status() || ae0 !== (15 - i <= 4) || dout1 !== m_fwft) begin
        fails++;
        $display("FAIL drain_status[%0d] std=%b fwft_dout=%h required=%b fwft_dout=%h", i, st0, dout1, exp_status(), m_fwft);
      end
    end
    step(0, 1, 8'h00, 0, 0);
    tests++;
    if (unf0 !== 1'b1 || dout0 !== 8'h0F || empty0 !== 1'b1 || st1 !== exp_status()) begin
      fails++;
      $display("FAIL underflow unf=%b dout=%h empty=%b required unf=1 dout=0f empty=1", unf0, dout0, empty0);
    end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 1, 8'h55, 0, 0);
    tests++;
    if (dout0 !== 8'h00 || count0 !== 5'd16 || full0 !== 1'b1 || ovf0 !== 1'b0 || dout1 !== 8'h01) begin
      fails++;
      $display("FAIL simul_full dout=%h count=%0d full=%b ovf=%b fwft=%h required dout=00 count=16 full=1 ovf=0 fwft=01",
               dout0, count0, full0, ovf0, dout1);
    end
    step(0, 0, 8'h00, 0, 1);
    step(1, 1, 8'h66, 0, 0);
    tests++;
    if (count0 !== 5'd1 || unf0 !== 1'b1 || dout0 !== 8'h00 || dout1 !== 8'h66 || st1 !== exp_status()) begin
      fails++;
      $display("FAIL simul_empty count=%0d unf=%b dout=%h fwft=%h required count=1 unf=1 dout=00 fwft=66",
               count0, unf0, dout0, dout1);
    end
  endtask

  task automatic test_wrap();
    bit w, r;
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 160; i++) begin
      w = 1'($urandom);
      r = 1'($urandom);
      if (q.size() >= 10) w = 1'b0;
      if (q.size() <= 3)  r = 1'b0;
      step(w, r, 8'($urandom), 0, 0);
      tests++;
      if (st0 !== exp_status() || st1 !== exp_status() || dout0 !== m_std || dout1 !== m_fwft) begin
        fails++;
        $display("FAIL wrap[%0d] std=%b/%h fwft=%b/%h required=%b/%h/%h",
                 i, st0, dout0, st1, dout1, exp_status(), m_std, m_fwft);
      end
    end
  endtask

  task automatic test_fwft();
    step(0, 0, 8'h00, 0, 1);
    step(1, 0, 8'h3C, 0, 0);
    tests++;
    if (empty1 !== 1'b0 || dout1 !== 8'h3C) begin
      fails++;
      $display("FAIL fwft_first empty=%b dout=%h required empty=0 dout=3c", empty1, dout1);
    end
    step(1, 0, 8'h3D, 0, 0);
    tests++;
    if (dout1 !== 8'h3C || count1 !== 5'd2) begin
      fails++;
      $display("FAIL fwft_hold dout=%h count=%0d required dout=3c count=2", dout1, count1);
    end
    step(0, 1, 8'h00, 0, 0);
    tests++;
    if (dout1 !== 8'h3D || count1 !== 5'd1 || dout0 !== 8'h3C) begin
      fails++;
      $display("FAIL fwft_pop dout=%h count=%0d std=%h required dout=3d count=1 std=3c", dout1, count1, dout0);
    end
  endtask

  task automatic test_reset_mid_and_clr();
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 8'($urandom), 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(1, 1, 8'h77, 0, 1);
    tests++;
    if (count0 !== 5'd0 || empty0 !== 1'b1 || dout0 !== 8'h00 || dout1 !== 8'h00 || count1 !== 5'd0) begin
      fails++;
      $display("FAIL reset_mid count=%0d empty=%b dout=%h fwft=%h required count=0 empty=1 dout=00 fwft=00",
               count0, empty0, dout0, dout1);
    end
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    tests++;
    if (unf0 !== 1'b0 || unf1 !== 1'b0) begin
      fails++;
      $display("FAIL clr_err unf=%b/%b required 0", unf0, unf1);
    end
    step(0, 1, 8'h00, 1, 0);
    tests++;
    if (unf0 !== 1'b1 || st0 !== exp_status()) begin
      fails++;
      $display("FAIL clr_set_wins unf=%b status=%b required unf=1 status=%b", unf0, st0, exp_status());
    end
  endtask

  task automatic test_random();
    bit w, r, c;
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 5);
      if (i > 200) begin w = !w; r = !r; end
      step(w, r, 8'($urandom), c, 0);
      tests++;
      if (st0 !== exp_status() || st1 !== exp_status() || dout0 !== m_std || dout1 !== m_fwft) begin
        fails++;
        $display("FAIL random[%0d] std=%b/%h fwft=%b/%h required=%b/%h/%h",
                 i, st0, dout0, st1, dout1, exp_status(), m_std, m_fwft);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_fwft();
    test_reset_mid_and_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
